// File: rtl/dcache.sv
// Direct-mapped write-back, write-allocate data cache: 8 lines of 2x64-bit words.
// Optional hit/miss statistics counters are built when DCACHE_STATS_EN is defined.
module dcache (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         proc_read,
   input  logic         proc_write,
   input  logic [29:0]  proc_addr,
   input  logic [63:0]  proc_wdata,
   output logic [63:0]  proc_rdata,
   output logic         proc_stall,
   output logic         mem_read,
   output logic         mem_write,
   output logic [28:0]  mem_addr,
   output logic [127:0] mem_wdata,
   input  logic [127:0] mem_rdata,
   input  logic         mem_ready
`ifdef DCACHE_STATS_EN
   ,
   output logic [15:0]  hit_cnt,
   output logic [15:0]  miss_cnt
`endif
);

   localparam logic [1:0] COMPARE   = 2'd0;
   localparam logic [1:0] WRITEBACK = 2'd1;
   localparam logic [1:0] ALLOCATE  = 2'd2;

   logic [1:0]  state_reg, state_next;
   logic [7:0]  valid_reg, dirty_reg;
   logic [25:0] tag_mem   [8];
   logic [63:0] word0_mem [8];
   logic [63:0] word1_mem [8];

   logic [25:0] req_tag;
   logic [2:0]  req_idx;
   logic        req_off;
   logic        req_any;
   logic        hit;
   logic        cmp_hit;
   logic        cmp_miss;
   logic        write_hit;
   logic        fill;

   assign req_tag = proc_addr[29:4];
   assign req_idx = proc_addr[3:1];
   assign req_off = proc_addr[0];
   assign req_any = proc_read | proc_write;

   assign hit       = req_any & valid_reg[req_idx] & (tag_mem[req_idx] == req_tag);
   assign cmp_hit   = (state_reg == COMPARE) & hit;
   assign cmp_miss  = (state_reg == COMPARE) & req_any & ~hit;
   // A simultaneous read and write is handled as a write.
   assign write_hit = cmp_hit & proc_write;
   assign fill      = (state_reg == ALLOCATE) & mem_ready;

   assign proc_rdata = req_off ? word1_mem[req_idx] : word0_mem[req_idx];

   always_comb begin
      proc_stall = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_addr   = 29'd0;
      mem_wdata  = 128'd0;
      state_next = state_reg;
      case (state_reg)
         COMPARE: begin
            if (cmp_miss) begin
               proc_stall = 1'b1;
               if (valid_reg[req_idx] && dirty_reg[req_idx])
                  state_next = WRITEBACK;
               else
                  state_next = ALLOCATE;
            end
         end
         WRITEBACK: begin
            proc_stall = 1'b1;
            mem_write  = 1'b1;
            mem_addr   = {tag_mem[req_idx], req_idx};
            mem_wdata  = {word1_mem[req_idx], word0_mem[req_idx]};
            if (mem_ready)
               state_next = ALLOCATE;
         end
         ALLOCATE: begin
            proc_stall = 1'b1;
            mem_read   = 1'b1;
            mem_addr   = proc_addr[29:1];
            if (mem_ready)
               state_next = COMPARE;
         end
         default: begin
            state_next = COMPARE;
         end
      endcase
   end

   // Control state is reset; the tag and data arrays below are not.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= COMPARE;
         valid_reg <= 8'd0;
         dirty_reg <= 8'd0;
      end else begin
         state_reg <= state_next;
         if (write_hit)
            dirty_reg[req_idx] <= 1'b1;
         if ((state_reg == WRITEBACK) && mem_ready)
            dirty_reg[req_idx] <= 1'b0;
         if (fill) begin
            valid_reg[req_idx] <= 1'b1;
            dirty_reg[req_idx] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (fill) begin
         tag_mem[req_idx]   <= req_tag;
         word0_mem[req_idx] <= mem_rdata[63:0];
         word1_mem[req_idx] <= mem_rdata[127:64];
      end else if (write_hit) begin
         if (req_off)
            word1_mem[req_idx] <= proc_wdata;
         else
            word0_mem[req_idx] <= proc_wdata;
      end
   end

`ifdef DCACHE_STATS_EN
   // retry_reg marks the first COMPARE cycle after a fill, whose hit is not counted.
   logic retry_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retry_reg <= 1'b0;
         hit_cnt   <= 16'd0;
         miss_cnt  <= 16'd0;
      end else begin
         retry_reg <= fill;
         if (cmp_hit && !retry_reg && (hit_cnt != 16'hFFFF))
            hit_cnt <= hit_cnt + 16'd1;
         if (cmp_miss && (miss_cnt != 16'hFFFF))
            miss_cnt <= miss_cnt + 16'd1;
      end
   end
`else
   // Statistics counters not built.
`endif

endmodule

// File: tb/tb_dcache.sv
// Scoreboard bench for dcache: stimulus queues expected events, a negedge monitor pops and checks them.
`timescale 1ns/1ps
module tb_dcache;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         proc_read, proc_write;
   logic [29:0]  proc_addr;
   logic [63:0]  proc_wdata;
   logic [63:0]  proc_rdata;
   logic         proc_stall;
   logic         mem_read, mem_write;
   logic [28:0]  mem_addr;
   logic [127:0] mem_wdata;
   logic [127:0] mem_rdata;
   logic         mem_ready;
`ifdef DCACHE_STATS_EN
   logic [15:0]  hit_cnt, miss_cnt;
`endif

   always #5 clk = ~clk;

   dcache dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .proc_read  (proc_read),
      .proc_write (proc_write),
      .proc_addr  (proc_addr),
      .proc_wdata (proc_wdata),
      .proc_rdata (proc_rdata),
      .proc_stall (proc_stall),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready)
`ifdef DCACHE_STATS_EN
      ,
      .hit_cnt    (hit_cnt),
      .miss_cnt   (miss_cnt)
`endif
   );

   localparam int K_RD = 0;
   localparam int K_WR = 1;
   localparam int K_MR = 2;
   localparam int K_MW = 3;

   typedef struct {
      int           kind;
      logic [28:0]  addr;
      logic [127:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end else begin
         $display("ok   %s = %0h", name, act);
      end
   endtask

   task automatic push(input int kind, input logic [28:0] addr, input logic [127:0] data);
      exp_t e;
      e.kind = kind;
      e.addr = addr;
      e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic pop_check(input int kind);
      exp_t e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_event kind=%0d actual=present required=none", kind);
         return;
      end
      e = exp_q.pop_front();
      check("event_kind", 128'(kind), 128'(e.kind));
      case (kind)
         K_RD: begin
            check("proc_rdata", {64'd0, proc_rdata}, {64'd0, e.data[63:0]});
            check("hit_mem_idle", {126'd0, mem_read, mem_write}, 128'd0);
         end
         K_WR: check("hit_mem_idle", {126'd0, mem_read, mem_write}, 128'd0);
         K_MR: check("mem_read_addr", {99'd0, mem_addr}, {99'd0, e.addr});
         default: begin
            check("mem_write_addr", {99'd0, mem_addr}, {99'd0, e.addr});
            check("mem_wdata", mem_wdata, e.data);
         end
      endcase
   endtask

   // Monitor: every DUT-presented event pops the next expected record.
   logic mr_prev = 1'b0;
   logic mw_prev = 1'b0;
   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_write && !mw_prev) begin
            check("mem_excl", {127'd0, mem_read}, 128'd0);
            pop_check(K_MW);
         end
         if (mem_read && !mr_prev) begin
            check("mem_excl", {127'd0, mem_write}, 128'd0);
            pop_check(K_MR);
         end
         if ((proc_read || proc_write) && !proc_stall)
            pop_check(proc_write ? K_WR : K_RD);
      end
      mr_prev <= mem_read;
      mw_prev <= mem_write;
   end

   // Drive one request, serve memory with a fixed latency, check stall cycle count.
   task automatic access(input logic rd, input logic wr, input logic [29:0] addr,
                         input logic [63:0] wdata, input logic [127:0] fill,
                         input int lat, input int exp_stall, input string name);
      int stalls = 0;
      int busy   = 0;
      proc_read  = rd;
      proc_write = wr;
      proc_addr  = addr;
      proc_wdata = wdata;
      mem_rdata  = fill;
      forever begin
         @(negedge clk);
         mem_ready = 1'b0;
         if (!proc_stall) break;
         stalls++;
         if (stalls > 200) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=stalled required=done", name);
            break;
         end
         if (mem_read || mem_write) begin
            busy++;
            if (busy >= lat) begin
               mem_ready = 1'b1;
               busy = 0;
            end
         end
      end
      check({name, "_stall_cycles"}, 128'(stalls), 128'(exp_stall));
      @(posedge clk);
      #1;
      proc_read  = 1'b0;
      proc_write = 1'b0;
   endtask

   initial begin
      rst_n      = 1'b0;
      proc_read  = 1'b0;
      proc_write = 1'b0;
      proc_addr  = 30'd0;
      proc_wdata = 64'd0;
      mem_rdata  = 128'd0;
      mem_ready  = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_mem_read", {127'd0, mem_read}, 128'd0);
      check("rst_mem_write", {127'd0, mem_write}, 128'd0);
      check("rst_mem_addr", {99'd0, mem_addr}, 128'd0);
      check("rst_mem_wdata", mem_wdata, 128'd0);
      check("rst_proc_stall", {127'd0, proc_stall}, 128'd0);
`ifdef DCACHE_STATS_EN
      check("rst_hit_cnt", {112'd0, hit_cnt}, 128'd0);
      check("rst_miss_cnt", {112'd0, miss_cnt}, 128'd0);
`endif
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Cold read miss, clean allocate.
      push(K_MR, 29'h2, 128'd0);
      push(K_RD, 29'd0, {64'd0, 64'hA});
      access(1'b1, 1'b0, 30'h4, 64'd0, {64'hB, 64'hA}, 3, 4, "rd_0x4");

      // Write hit then read back.
      push(K_WR, 29'd0, 128'd0);
      access(1'b0, 1'b1, 30'h5, 64'h1234, 128'd0, 1, 0, "wr_0x5");
      push(K_RD, 29'd0, {64'd0, 64'h1234});
      access(1'b1, 1'b0, 30'h5, 64'd0, 128'd0, 1, 0, "rd_0x5");

      // Conflict miss on dirty line: writeback then allocate.
      push(K_MW, 29'h2, {64'h1234, 64'hA});
      push(K_MR, 29'hA, 128'd0);
      push(K_RD, 29'd0, {64'd0, 64'hC});
      access(1'b1, 1'b0, 30'h14, 64'd0, {64'hD, 64'hC}, 2, 5, "rd_0x14");
`ifdef DCACHE_STATS_EN
      check("hit_cnt_after_seq", {112'd0, hit_cnt}, 128'd2);
      check("miss_cnt_after_seq", {112'd0, miss_cnt}, 128'd2);
`endif

      // Stray mem_ready while idle in COMPARE must be ignored.
      @(negedge clk);
      mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      @(posedge clk);
      #1;
      push(K_RD, 29'd0, {64'd0, 64'hC});
      access(1'b1, 1'b0, 30'h14, 64'd0, 128'd0, 1, 0, "rd_0x14_hit");
`ifdef DCACHE_STATS_EN
      check("miss_cnt_after_stray", {112'd0, miss_cnt}, 128'd2);
`endif

      // Read and write together act as a write; write miss allocates then stores.
      push(K_MR, 29'h11, 128'd0);
      push(K_WR, 29'd0, 128'd0);
      access(1'b1, 1'b1, 30'h23, 64'h55, {64'hF, 64'hE}, 1, 2, "rdwr_0x23");
      push(K_RD, 29'd0, {64'd0, 64'h55});
      access(1'b1, 1'b0, 30'h23, 64'd0, 128'd0, 1, 0, "rd_0x23");
      push(K_RD, 29'd0, {64'd0, 64'hE});
      access(1'b1, 1'b0, 30'h22, 64'd0, 128'd0, 1, 0, "rd_0x22");
      push(K_MW, 29'h11, {64'h55, 64'hE});
      push(K_MR, 29'h1, 128'd0);
      push(K_RD, 29'd0, {64'd0, 64'h77});
      access(1'b1, 1'b0, 30'h2, 64'd0, {64'h88, 64'h77}, 1, 3, "rd_0x2");

      // Reset during ALLOCATE aborts the read at once.
      push(K_MR, 29'h1A, 128'd0);
      proc_read = 1'b1;
      proc_addr = 30'h34;
      repeat (3) @(negedge clk);
      check("alloc_mem_read", {127'd0, mem_read}, 128'd1);
      #2 rst_n = 1'b0;
      #1;
      check("abort_alloc_mem_read", {127'd0, mem_read}, 128'd0);
      check("abort_alloc_mem_addr", {99'd0, mem_addr}, 128'd0);
      proc_read = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Previously valid line misses again after reset; store makes it dirty.
      push(K_MR, 29'hA, 128'd0);
      push(K_WR, 29'd0, 128'd0);
      access(1'b0, 1'b1, 30'h14, 64'h99, {64'hD, 64'hC}, 1, 2, "wr_0x14_after_rst");

      // Reset during WRITEBACK discards the dirty line without a memory write.
      push(K_MW, 29'hA, {64'hD, 64'h99});
      proc_read = 1'b1;
      proc_addr = 30'h34;
      repeat (2) @(negedge clk);
      check("wb_mem_write", {127'd0, mem_write}, 128'd1);
      #2 rst_n = 1'b0;
      #1;
      check("abort_wb_mem_write", {127'd0, mem_write}, 128'd0);
      check("abort_wb_mem_wdata", mem_wdata, 128'd0);
      proc_read = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      push(K_MR, 29'h1A, 128'd0);
      push(K_RD, 29'd0, {64'd0, 64'h5A});
      access(1'b1, 1'b0, 30'h34, 64'd0, {64'hA5, 64'h5A}, 2, 3, "rd_0x34_after_rst");
      push(K_MR, 29'hA, 128'd0);
      push(K_RD, 29'd0, {64'd0, 64'hC});
      access(1'b1, 1'b0, 30'h14, 64'd0, {64'hD, 64'hC}, 1, 2, "rd_0x14_refill");

      repeat (3) @(negedge clk);
      check("scoreboard_empty", 128'(exp_q.size()), 128'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
